// File: rtl/q_flop_sync.sv
// q_flop_sync: qualified sampling register that holds a capture through a resolution window before publishing it
module q_flop_sync #(
    parameter int WIDTH          = 1,
    parameter int RESOLVE_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    output logic             ack,
    output logic [WIDTH-1:0] out
);
    localparam int CW = (RESOLVE_CYCLES > 1) ? $clog2(RESOLVE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(RESOLVE_CYCLES - 1);

    if (RESOLVE_CYCLES < 1) begin : g_bad_resolve
        $error("q_flop_sync: RESOLVE_CYCLES must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("q_flop_sync: WIDTH must be >= 1");
    end

    typedef enum logic {IDLE, RESOLVE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] hold, hold_n, out_n, clean;
    logic             ack_n;

    // any bit not definitely 1 (including X/Z) settles to 0 at capture
    always_comb begin
        clean = '0;
        for (int i = 0; i < WIDTH; i++)
            if (data[i]) clean[i] = 1'b1;
    end

    // idle captures and starts the window; resolve counts down, then publishes the held sample
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hold_n  = hold;
        out_n   = out;
        ack_n   = ack;
        if (state == IDLE) begin
            state_n = RESOLVE;
            cnt_n   = RELOAD;
            hold_n  = clean;
            ack_n   = 1'b0;
        end else if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
        end else begin
            state_n = IDLE;
            out_n   = hold;
            ack_n   = 1'b1;
        end
    end

    // state register; reset discards any pending sample at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
            out   <= '0;
            ack   <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hold  <= hold_n;
            out   <= out_n;
            ack   <= ack_n;
        end
    end
endmodule

// File: tb/tb_q_flop_sync.sv
// tb_q_flop_sync: randomized check of two q_flop_sync configurations against an edge-count model
module tb_q_flop_sync;
    logic       clock = 1'b1;
    logic       reset = 1'b0;
    logic       run   = 1'b0;
    logic [3:0] data_a = 4'h1;
    logic [7:0] data_b = 8'hA5;
    logic       ack_a, ack_b;
    logic [3:0] out_a;
    logic [7:0] out_b;
    int total = 0;
    int bad   = 0;

    q_flop_sync #(.WIDTH(4), .RESOLVE_CYCLES(2)) dut_a (
        .clock(clock), .reset(reset), .data(data_a), .ack(ack_a), .out(out_a)
    );
    q_flop_sync #(.WIDTH(8), .RESOLVE_CYCLES(1)) dut_b (
        .clock(clock), .reset(reset), .data(data_b), .ack(ack_b), .out(out_b)
    );

    always #10 if (run) clock = ~clock;

    // model: a sample captured on edge n while idle is published on edge n+R
    int          rc [2] = '{2, 1};
    int          n [2], pub [2];
    logic [31:0] m_out [2], pend [2];
    logic        m_ack [2];

    always @(posedge clock or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_out[i] = 0;
                m_ack[i] = 1'b1;
                n[i]     = 0;
                pub[i]   = 0;
            end else begin
                n[i]++;
                if (!m_ack[i] && n[i] == pub[i]) begin
                    m_out[i] = pend[i];
                    m_ack[i] = 1'b1;
                end else if (m_ack[i]) begin
                    pend[i]  = (i == 0) ? 32'(data_a) : 32'(data_b);
                    pub[i]   = n[i] + rc[i];
                    m_ack[i] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // every falling edge outside reset, both DUTs must match the model
    always @(negedge clock) begin
        if (!reset) begin
            chk("model_out_a", 32'(out_a), m_out[0]);
            chk("model_ack_a", 32'(ack_a), 32'(m_ack[0]));
            chk("model_out_b", 32'(out_b), m_out[1]);
            chk("model_ack_b", 32'(ack_b), 32'(m_ack[1]));
        end
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #3 reset = 1'b1;
        #1;
        chk("rst_out_a", 32'(out_a), 0);
        chk("rst_ack_a", 32'(ack_a), 1);
        chk("rst_out_b", 32'(out_b), 0);
        #5 reset = 1'b0;
        #1;
        chk("rel_out_a", 32'(out_a), 0);
        chk("rel_ack_a", 32'(ack_a), 1);
        chk("rel_ack_b", 32'(ack_b), 1);
        run = 1'b1;
        step();
        chk("e0_ack_a", 32'(ack_a), 0);
        chk("e0_out_a", 32'(out_a), 0);
        chk("e0_ack_b", 32'(ack_b), 0);
        data_a = 4'h0;
        step();
        chk("e1_ack_a", 32'(ack_a), 0);
        chk("e1_out_a", 32'(out_a), 0);
        chk("e1_ack_b", 32'(ack_b), 1);
        chk("e1_out_b", 32'(out_b), 32'hA5);
        data_b = 8'h3C;
        step();
        chk("e2_ack_a", 32'(ack_a), 1);
        chk("e2_out_a", 32'(out_a), 1);
        chk("e2_ack_b", 32'(ack_b), 0);
        chk("e2_out_b", 32'(out_b), 32'hA5);
        step();
        chk("e3_ack_a", 32'(ack_a), 0);
        chk("e3_out_a", 32'(out_a), 1);
        chk("e3_ack_b", 32'(ack_b), 1);
        chk("e3_out_b", 32'(out_b), 32'h3C);
        step();
        chk("e4_ack_a", 32'(ack_a), 0);
        step();
        chk("e5_ack_a", 32'(ack_a), 1);
        chk("e5_out_a", 32'(out_a), 0);
        data_a = 4'h1;
        step();
        chk("mid_ack_a", 32'(ack_a), 0);
        step();
        chk("mid2_ack_a", 32'(ack_a), 0);
        #3 reset = 1'b1;
        #1;
        chk("abort_out_a", 32'(out_a), 0);
        chk("abort_ack_a", 32'(ack_a), 1);
        #2 reset = 1'b0;
        step();
        chk("fresh_ack_a", 32'(ack_a), 0);
        chk("fresh_out_a", 32'(out_a), 0);
        step();
        step();
        chk("fresh_pub_ack_a", 32'(ack_a), 1);
        chk("fresh_pub_out_a", 32'(out_a), 1);
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            #2;
            data_a = 4'($urandom);
            data_b = 8'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                #3 reset = 1'b1;
                #2 reset = 1'b0;
            end
            if ($urandom_range(0, 60) == 0) begin
                run = 1'b0;
                #137;
                chk("frozen_out_a", 32'(out_a), m_out[0]);
                chk("frozen_ack_a", 32'(ack_a), 32'(m_ack[0]));
                chk("frozen_out_b", 32'(out_b), m_out[1]);
                run = 1'b1;
                #3;
            end
        end
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
